// File: rtl/alu_flag_stage.sv
// alu_flag_stage: EX-stage result/flag register with branch-condition evaluation and overflow event counter
module alu_flag_stage #(
  parameter int DW    = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       opcode,
  input  logic [DW-1:0]    alu_out,
  input  logic             ovfl,
  input  logic [2:0]       cond,
  output logic [DW-1:0]    ex_result,
  output logic             ex_valid,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_hazard,
  output logic             br_taken,
  output logic [CNT_W-1:0] ovfl_count
);
  logic w_arith, w_logic;
  assign w_arith = opcode[3:1] == 3'b000;
  assign w_logic = opcode == 4'b0010 || opcode == 4'b0100 || opcode == 4'b0101 || opcode == 4'b0110;
  assign flag_hazard = in_valid & ~flush & ~rst & (w_arith | w_logic);
  // branch sees only committed flags; decode stalls on flag_hazard instead of bypassing
  always_comb begin
    br_taken = (cond == 3'd0) ? ~flag_z :
               (cond == 3'd1) ? flag_z :
               (cond == 3'd2) ? (~flag_z & ~flag_n) :
               (cond == 3'd3) ? flag_n :
               (cond == 3'd4) ? (flag_z | ~flag_n) :
               (cond == 3'd5) ? (flag_n | flag_z) :
               (cond == 3'd6) ? flag_v : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_result  <= '0;
      ex_valid   <= 1'b0;
      flag_z     <= 1'b0;
      flag_v     <= 1'b0;
      flag_n     <= 1'b0;
      ovfl_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (!stall) begin
      ex_valid <= in_valid;
      if (in_valid) begin
        ex_result <= alu_out;
        if (w_arith | w_logic) flag_z <= alu_out == '0;
        if (w_arith) begin
          flag_n <= alu_out[DW-1];
          flag_v <= ovfl;
          if (ovfl && ovfl_count != '1) ovfl_count <= ovfl_count + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_flag_stage.sv
// tb_alu_flag_stage: directed-vector bench for alu_flag_stage, including a CNT_W=2 instance for counter saturation
module tb_alu_flag_stage;
  logic        clk, rst, rst2, stall, flush, in_valid, ovfl;
  logic [3:0]  opcode;
  logic [15:0] alu_out;
  logic [2:0]  cond;
  logic [15:0] ex_result, ex_result2;
  logic        ex_valid, flag_z, flag_v, flag_n, flag_hazard, br_taken;
  logic        ex_valid2, flag_z2, flag_v2, flag_n2, flag_hazard2, br_taken2;
  logic [7:0]  ovfl_count;
  logic [1:0]  ovfl_count2;
  int n_cmp = 0;
  int n_err = 0;

  alu_flag_stage #(.DW(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .alu_out(alu_out), .ovfl(ovfl), .cond(cond),
    .ex_result(ex_result), .ex_valid(ex_valid), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .flag_hazard(flag_hazard), .br_taken(br_taken), .ovfl_count(ovfl_count)
  );

  alu_flag_stage #(.DW(16), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst2), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .alu_out(alu_out), .ovfl(ovfl), .cond(cond),
    .ex_result(ex_result2), .ex_valid(ex_valid2), .flag_z(flag_z2), .flag_v(flag_v2),
    .flag_n(flag_n2), .flag_hazard(flag_hazard2), .br_taken(br_taken2), .ovfl_count(ovfl_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, input logic o);
    in_valid = v; opcode = op; alu_out = a; ovfl = o;
  endtask

  // state vector layout: {ex_valid, ex_result, Z, N, V, ovfl_count}
  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    drive(1'b1, 4'b0000, 16'h1234, 1'b1);
    #1;
    n_cmp++;
    if (flag_hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard got %b exp 0", flag_hazard); end
    step(); step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b0, 16'h0000, 3'b000, 8'd0}) begin
      n_err++; $display("FAIL reset_state got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b0, 16'h0000, 3'b000, 8'd0});
    end
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_add_ovfl();
    drive(1'b1, 4'b0000, 16'h7FFF, 1'b1);
    #1;
    n_cmp++;
    if (flag_hazard !== 1'b1) begin n_err++; $display("FAIL add_hazard got %b exp 1", flag_hazard); end
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b1, 16'h7FFF, 3'b001, 8'd1}) begin
      n_err++; $display("FAIL add_7fff got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b1, 16'h7FFF, 3'b001, 8'd1});
    end
    drive(1'b1, 4'b0000, 16'h8000, 1'b1);
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b1, 16'h8000, 3'b011, 8'd2}) begin
      n_err++; $display("FAIL add_8000 got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b1, 16'h8000, 3'b011, 8'd2});
    end
  endtask

  task automatic test_partial();
    drive(1'b1, 4'b0001, 16'h8000, 1'b1);
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b1, 16'h8000, 3'b011, 8'd3}) begin
      n_err++; $display("FAIL sub_set got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b1, 16'h8000, 3'b011, 8'd3});
    end
    drive(1'b1, 4'b0010, 16'h0000, 1'b1);
    #1;
    n_cmp++;
    if (flag_hazard !== 1'b1) begin n_err++; $display("FAIL xor_hazard got %b exp 1", flag_hazard); end
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b1, 16'h0000, 3'b111, 8'd3}) begin
      n_err++; $display("FAIL xor_zero got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b1, 16'h0000, 3'b111, 8'd3});
    end
    drive(1'b1, 4'b0001, 16'h0001, 1'b0);
    step();
    drive(1'b1, 4'b0111, 16'h0000, 1'b1);
    #1;
    n_cmp++;
    if (flag_hazard !== 1'b0) begin n_err++; $display("FAIL paddsb_hazard got %b exp 0", flag_hazard); end
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b1, 16'h0000, 3'b000, 8'd3}) begin
      n_err++; $display("FAIL paddsb_hold got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b1, 16'h0000, 3'b000, 8'd3});
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 4'b0000, 16'h8000, 1'b1);
    step();
    drive(1'b1, 4'b0001, 16'h0000, 1'b0);
    stall = 1'b1;
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b1, 16'h8000, 3'b011, 8'd4}) begin
      n_err++; $display("FAIL stall_hold got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b1, 16'h8000, 3'b011, 8'd4});
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (flag_hazard !== 1'b0) begin n_err++; $display("FAIL flush_hazard got %b exp 0", flag_hazard); end
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b0, 16'h8000, 3'b011, 8'd4}) begin
      n_err++; $display("FAIL stall_flush got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b0, 16'h8000, 3'b011, 8'd4});
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_idle();
    drive(1'b1, 4'b0000, 16'h0005, 1'b0);
    step();
    drive(1'b0, 4'b0000, 16'hFFFF, 1'b1);
    #1;
    n_cmp++;
    if (flag_hazard !== 1'b0) begin n_err++; $display("FAIL idle_hazard got %b exp 0", flag_hazard); end
    step();
    n_cmp++;
    if ({ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count} !== {1'b0, 16'h0005, 3'b000, 8'd4}) begin
      n_err++; $display("FAIL idle_hold got %h exp %h", {ex_valid, ex_result, flag_z, flag_n, flag_v, ovfl_count}, {1'b0, 16'h0005, 3'b000, 8'd4});
    end
  endtask

  task automatic sweep(input string name, input logic [7:0] exp_tbl);
    logic [7:0] tbl;
    tbl = exp_tbl;
    for (int c = 0; c < 8; c++) begin
      cond = 3'(c);
      #1;
      n_cmp++;
      if (br_taken !== tbl[c]) begin n_err++; $display("FAIL br_%s_c%0d got %b exp %b", name, c, br_taken, tbl[c]); end
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 4'b0000, 16'h0001, 1'b0); step(); drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    sweep("znv000", 8'b1001_0101);
    drive(1'b1, 4'b0000, 16'h0000, 1'b0);
    cond = 3'd1;
    #1;
    n_cmp++;
    if (br_taken !== 1'b0) begin n_err++; $display("FAIL br_no_bypass got %b exp 0", br_taken); end
    step(); drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    sweep("znv100", 8'b1011_0010);
    drive(1'b1, 4'b0001, 16'h8001, 1'b0); step(); drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    sweep("znv010", 8'b1010_1001);
    drive(1'b1, 4'b0000, 16'h0001, 1'b1); step(); drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    sweep("znv001", 8'b1101_0101);
  endtask

  task automatic test_sat();
    logic [1:0] exp_cnt;
    rst2 = 1'b1; step(); rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 16'h7FFF, 1'b1);
      step();
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_cmp++;
      if (ovfl_count2 !== exp_cnt) begin n_err++; $display("FAIL sat_cnt_%0d got %0d exp %0d", i, ovfl_count2, exp_cnt); end
    end
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; flush = 1'b0; cond = 3'd0;
    drive(1'b0, 4'b0000, 16'h0000, 1'b0);
    test_reset();
    test_add_ovfl();
    test_partial();
    test_stall_flush();
    test_idle();
    test_branch();
    test_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- EX-stage result/flag register placed directly downstream of the 16-bit saturating add/sub unit and the other ALU datapaths.
- Each cycle it captures the ALU result and the adder overflow, and updates the Z/V/N flag register according to opcode class.
- It evaluates the 3-bit branch condition against the registered flags for the branch unit.
- It keeps a saturating count of overflow events for debug.

Parameters:
- DW, 16, datapath width of result and ALU input.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold all state this cycle.
- flush  in  1  kill the incoming op; result is invalid next cycle.
- in_valid  in  1  opcode/alu_out/ovfl are valid this cycle.
- opcode  in  4  instruction opcode.
- alu_out  in  DW  ALU result, already saturated by the adder.
- ovfl  in  1  adder saturation/overflow indicator.
- cond  in  3  branch condition code from decode.
- ex_result  out  DW  registered ALU result.
- ex_valid  out  1  ex_result holds a live op.
- flag_z, flag_v, flag_n  out  1 each  registered flags.
- flag_hazard  out  1  a valid, un-flushed, flag-writing op is in this cycle's input.
- br_taken  out  1  condition true on the registered flags (combinational).
- ovfl_count  out  CNT_W  saturating count of committed V=1 events.

Behaviour:
- Reset: on a clk edge with rst=1, ex_result=0, ex_valid=0, all flags=0, ovfl_count=0. Reset overrides stall and flush.
- Priority on each edge: rst > flush > stall > in_valid > idle.
- flush=1:
  - ex_valid<=0.
  - ex_result, flags and ovfl_count are unchanged.
  - flush with stall: flush wins.
- stall=1 (no flush): every register holds, including ex_valid.
- in_valid=1: ex_result<=alu_out; ex_valid<=1. Flags update per opcode class:
  - 0000 ADD, 0001 SUB: Z<=(alu_out==0), N<=alu_out[DW-1], V<=ovfl.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: Z<=(alu_out==0); N and V hold.
  - All other opcodes (RED, PADDSB, memory, LHB/LLB, branch, PCS, HLT): no flag change.
- Flag values are derived from the saturated alu_out. A saturated 16'h8000 gives N=1, Z=0, V=1.
- ovfl on a non-ADD/SUB opcode is ignored for both flags and the counter.
- ovfl_count increments by 1 when an ADD/SUB commits with ovfl=1. It saturates at all-ones and never wraps.
- in_valid=0 (no stall, no flush): ex_valid<=0; the other registers hold.
- Latency: exactly 1 cycle from input to ex_result and flags.
- flag_hazard = in_valid & ~flush & ~rst & (opcode is ADD, SUB, XOR, SLL, SRA or ROR). It is combinational. Decode uses it to stall a dependent branch for one cycle.
- br_taken is combinational on the registered flags:
  - 000: ~Z
  - 001: Z
  - 010: ~Z & ~N
  - 011: N
  - 100: Z | (~Z & ~N)
  - 101: N | Z
  - 110: V
  - 111: 1
- br_taken does not bypass the in-flight flag update.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1, opcode=ADD, alu_out=16'h1234 -> ex_valid=0, ex_result=0, Z=V=N=0, ovfl_count=0 after the edge.
- ADD overflow: opcode=0000, alu_out=16'h7FFF, ovfl=1 -> next cycle ex_result=7FFF, Z=0, N=0, V=1, ovfl_count=1. Then alu_out=16'h8000, ovfl=1 -> N=1, V=1, ovfl_count=2.
- Partial flag update: set Z=0, N=1, V=1 via SUB; then XOR with alu_out=0 -> Z=1, N=1, V=1 held. Then PADDSB with alu_out=0, ovfl=1 -> all flags and ovfl_count unchanged.
- Stall/flush: SUB alu_out=0 with stall=1 -> nothing changes. Same op with stall=1, flush=1 -> ex_valid=0, flags unchanged, flag_hazard=0.
- Branch conditions: for each flag combination {Z,N,V} in {000, 100, 010, 001}, sweep cond 0-7 -> br_taken matches the table. For example Z=0, N=0: cond=010 -> 1; cond=101 -> 0.
- Counter saturation: CNT_W=2, five consecutive ADDs with ovfl=1 -> ovfl_count goes 1, 2, 3, 3, 3.
